// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, default widths and FSM states.
package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OPW   = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally on dout.
module alu_cmd_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for a combinational ALU: queues commands, drives registered operands,
// captures the result and returns it over a valid/ready response stream.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OPW-1:0]   rsp_opcode,
  output logic             busy
);

  localparam int EW = OPW + 2 * WIDTH + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state_r;
  state_t           state_s;
  logic             load_s;
  logic             cap_s;
  logic             done_s;
  logic [WIDTH-1:0] acc_r;
  logic [EW-1:0]    head_s;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  alu_cmd_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && !fifo_full),
    .din   ({cmd_opcode, cmd_a, cmd_b, cmd_chain}),
    .pop   (load_s),
    .dout  (head_s),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state_r != IDLE) || !fifo_empty;

  // Next-state logic; load_s pops the FIFO head into the ALU operand registers.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    cap_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          load_s  = 1'b1;
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        cap_s   = 1'b1;
        state_s = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          done_s = 1'b1;
          if (!fifo_empty) begin
            load_s  = 1'b1;
            state_s = EXEC;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, ALU operand, accumulator and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      alu_opcode <= {OPW{1'b0}};
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_data   <= {WIDTH{1'b0}};
      rsp_opcode <= {OPW{1'b0}};
    end else begin
      state_r <= state_s;
      if (load_s) begin
        alu_opcode <= head_s[EW-1 -: OPW];
        alu_a      <= head_s[0] ? acc_r : head_s[2*WIDTH -: WIDTH];
        alu_b      <= head_s[WIDTH -: WIDTH];
      end
      if (cap_s) begin
        rsp_data   <= alu_result;
        acc_r      <= alu_result;
        rsp_opcode <= alu_opcode;
        rsp_valid  <= 1'b1;
      end else if (done_s) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench for alu_cmd_driver with a behavioural ALU attached.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_chain;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_opcode;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int rsp_cyc    = 0;
  int prev_cyc   = 0;

  alu_cmd_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_opcode (rsp_opcode),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_opcode)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a ^ alu_b;
      3'd3:    alu_result = alu_a & alu_b;
      3'd4:    alu_result = alu_a | alu_b;
      3'd5:    alu_result = alu_a + 16'd1;
      3'd6:    alu_result = alu_a << alu_b[3:0];
      default: alu_result = alu_a >> alu_b[3:0];
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ch);
    int n = 0;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin tick(); n++; end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [15:0] d, input logic [2:0] op);
    int n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, d});
    chk({tag, "_op"}, {29'd0, rsp_opcode}, {29'd0, op});
    rsp_cyc = cyc;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_a = 16'd0; cmd_b = 16'd0;
    cmd_chain = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic ADD with cycle-exact latency
    push(3'd0, 16'h0003, 16'h0004, 1'b0);
    chk("basic_busy_e0", {31'd0, busy}, 32'd1);
    chk("basic_nv_e0", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("basic_alu_op", {29'd0, alu_opcode}, 32'd0);
    chk("basic_alu_a", {16'd0, alu_a}, 32'h0003);
    chk("basic_alu_b", {16'd0, alu_b}, 32'h0004);
    chk("basic_nv_e1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("basic_valid_e2", {31'd0, rsp_valid}, 32'd1);
    chk("basic_data", {16'd0, rsp_data}, 32'h0007);
    chk("basic_op", {29'd0, rsp_opcode}, 32'd0);
    tick();
    chk("basic_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);

    // Chaining: second command takes A from the previous result
    push(3'd0, 16'h0005, 16'h0006, 1'b0);
    push(3'd6, 16'hFFFF, 16'h0001, 1'b1);
    expect_rsp("chain1", 16'h000B, 3'd0);
    chk("chain_alu_a", {16'd0, alu_a}, 32'h000B);
    chk("chain_alu_op", {29'd0, alu_opcode}, 32'd6);
    expect_rsp("chain2", 16'h0016, 3'd6);

    // Backpressure and FIFO full
    tick();
    rsp_ready = 1'b0;
    push(3'd0, 16'h0001, 16'h0002, 1'b0);
    push(3'd1, 16'h000A, 16'h0003, 1'b0);
    push(3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    push(3'd3, 16'hF0F0, 16'h0FF0, 1'b0);
    push(3'd4, 16'h1200, 16'h0034, 1'b0);
    cmd_opcode = 3'd5; cmd_a = 16'h1111; cmd_b = 16'h0000; cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_hold_data", {16'd0, rsp_data}, 32'h0003);
      chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_busy", {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    expect_rsp("drain1", 16'h0003, 3'd0);
    prev_cyc = rsp_cyc;
    expect_rsp("drain2", 16'h0007, 3'd1);
    chk("thru2", rsp_cyc - prev_cyc, 32'd2);
    prev_cyc = rsp_cyc;
    expect_rsp("drain3", 16'hFF00, 3'd2);
    chk("thru3", rsp_cyc - prev_cyc, 32'd2);
    prev_cyc = rsp_cyc;
    expect_rsp("drain4", 16'h00F0, 3'd3);
    chk("thru4", rsp_cyc - prev_cyc, 32'd2);
    prev_cyc = rsp_cyc;
    expect_rsp("drain5", 16'h1234, 3'd4);
    chk("thru5", rsp_cyc - prev_cyc, 32'd2);
    tick();
    chk("drain_busy", {31'd0, busy}, 32'd0);
    chk("drain_ready", {31'd0, cmd_ready}, 32'd1);

    // Wrap-around values pass through unmodified
    push(3'd1, 16'h0000, 16'h0001, 1'b0);
    expect_rsp("wrap_sub", 16'hFFFF, 3'd1);
    push(3'd5, 16'hFFFF, 16'h0000, 1'b0);
    expect_rsp("wrap_inc", 16'h0000, 3'd5);
    push(3'd7, 16'h8001, 16'h0001, 1'b0);
    expect_rsp("wrap_shr", 16'h4000, 3'd7);

    // Asynchronous reset during EXEC
    tick();
    push(3'd0, 16'h0010, 16'h0001, 1'b0);
    push(3'd1, 16'h0020, 16'h0001, 1'b0);
    push(3'd2, 16'h0030, 16'h0001, 1'b0);
    tick();
    chk("mid_exec_op", {29'd0, alu_opcode}, 32'd1);
    chk("mid_exec_nv", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_alu_op", {29'd0, alu_opcode}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    push(3'd0, 16'h0001, 16'h0001, 1'b0);
    expect_rsp("post_rst_add", 16'h0002, 3'd0);

    // Simultaneous push and pop keeps the count
    tick();
    rsp_ready = 1'b0;
    push(3'd4, 16'h00A0, 16'h000B, 1'b0);
    push(3'd2, 16'h00FF, 16'h000F, 1'b0);
    tick();
    chk("pp_resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pp_resp_data", {16'd0, rsp_data}, 32'h00AB);
    chk("pp_count_before", {29'd0, dut.fifo_count}, 32'd1);
    rsp_ready = 1'b1;
    push(3'd3, 16'h0F0F, 16'h00FF, 1'b0);
    chk("pp_count_after", {29'd0, dut.fifo_count}, 32'd1);
    chk("pp_exec_op", {29'd0, alu_opcode}, 32'd2);
    expect_rsp("pp_second", 16'h00F0, 3'd2);
    expect_rsp("pp_third", 16'h000F, 3'd3);
    tick();
    chk("pp_busy_end", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator side of the 16-bit, 8-opcode combinational ALU interface (opcode/A/B in, Result out).
- Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives opcode/A/B from registers, captures the result, and returns it over a valid/ready response stream.
- Optional chaining feeds the previous result back as operand A, so the datapath can run multi-step ALU sequences without software round trips.

Parameters:
- WIDTH, 16, operand/result width; matches the ALU data width.
- OPW, 3, opcode width.
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_opcode  input  OPW  ALU operation.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_chain  input  1  1 = use the last captured result as A; cmd_a is ignored.
- alu_opcode  output  OPW  registered opcode to the ALU.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_result  input  WIDTH  combinational ALU result.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  captured result.
- rsp_opcode  output  OPW  opcode that produced rsp_data.
- busy  output  1  high when state != IDLE or the FIFO is not empty.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty; cmd_ready=1; state=IDLE; alu_opcode/alu_a/alu_b=0; rsp_valid=0; rsp_data=0; rsp_opcode=0; chain accumulator acc=0; busy=0. Reset mid-operation discards FIFO contents and any in-flight or held response.
- Push: a command is written when cmd_valid && cmd_ready at a rising edge. Entry = {opcode, a, b, chain}.
- cmd_ready = !full, computed from the registered count. There is no push-when-full, so the count never exceeds DEPTH.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if the FIFO is not empty, pop the head and load alu_opcode, alu_a, alu_b, then go to EXEC. alu_a = acc when chain=1, else the stored a.
- EXEC: exactly one cycle with ALU inputs stable. At the next edge:
  - rsp_data <= alu_result; acc <= alu_result;
  - rsp_opcode <= alu_opcode; rsp_valid <= 1;
  - go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid && rsp_ready:
  - rsp_valid <= 0;
  - if the FIFO is not empty, pop and load the ALU registers in the same edge and go to EXEC (back-to-back);
  - otherwise go to IDLE.
- Latency: command accepted at edge E0 into an empty FIFO with state IDLE → popped at E1 → rsp_valid high after E2.
- Throughput: one result per 2 cycles with rsp_ready held high.
- Simultaneous push and pop in the same edge: both take effect and the count is unchanged. A push arriving while the FIFO is empty and the state is IDLE is not bypassed; it is popped on the following edge.
- ALU registers hold their last values in IDLE and RESP. The ALU is treated as combinational on all three inputs.
- Chaining uses acc as last updated in EXEC. chain=1 on the first command after reset uses A=0.
- Arithmetic (wrap mod 2^WIDTH, shifts) belongs to the ALU. The driver transports values unmodified.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ADD=0, SUB=1, XOR=2, AND=3, OR=4, INC=5, SHL=6, SHR=7;
  - OPW and WIDTH defaults;
  - FSM state encoding (IDLE, EXEC, RESP).
- Sub-module alu_cmd_fifo: synchronous FIFO, width OPW+2*WIDTH+1, depth DEPTH, full/empty/count outputs, same clk/rst_n.
- The FSM and response registers live in alu_cmd_driver.

Test Plan:
- Basic: after reset, one ADD with A=0x0003, B=0x0004, rsp_ready=1 → alu_opcode=0 from E1; rsp_valid after E2 with rsp_data=0x0007, rsp_opcode=0; busy returns to 0 one cycle after the handshake.
- Chain: ADD 0x0005+0x0006, then SHL chain=1 with cmd_a=0xFFFF → responses 0x000B then 0x0016, in order; alu_a=0x000B during the second EXEC.
- Backpressure/full: rsp_ready=0, then issue 6 commands back-to-back → first popped, next 4 fill the FIFO; cmd_ready low after 5 accepts; rsp_data stable; raising rsp_ready drains 5 responses in order, one per 2 cycles.
- Wrap: SUB 0x0000-0x0001 → 0xFFFF; INC 0xFFFF → 0x0000; SHR 0x8001 → 0x4000.
- Reset mid-operation: 3 commands queued, rst_n pulsed low during EXEC → rsp_valid=0, cmd_ready=1, busy=0 immediately (asynchronously); no stale responses after release; a new ADD 1+1 returns 0x0002.
- Push/pop same edge: FIFO at 1 entry in RESP, push while handshaking → count stays 1; ordering preserved.
